jedro_1_lsu: RTL and testbench

// Load-store unit of the jedro_1 core. It accepts one load/store request at a time from the

---
 rtl/jedro_1_lsu_if.sv | 15 +
 rtl/jedro_1_lsu.sv | 114 +++++++++++
 tb/tb_jedro_1_lsu.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/jedro_1_lsu_if.sv
// jedro_1_lsu_if: byte-write data-RAM port between the load-store unit (master) and the RAM (slave).
interface jedro_1_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            we;
    logic                  stb;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;
    logic                  err;
    modport master (output we, stb, addr, wdata, input rdata, ack, err);
    modport slave  (input we, stb, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/jedro_1_lsu.sv
// jedro_1_lsu: single-outstanding load-store unit with byte-lane steering, alignment check,
// bus timeout and sign/zero-extended load write-back.
module jedro_1_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      ctrl_valid_i,
    output logic                      ctrl_ready_o,
    input  logic                      ctrl_we_i,
    input  logic [1:0]                ctrl_width_i,
    input  logic                      ctrl_sign_ext_i,
    input  logic [ADDR_WIDTH-1:0]     ctrl_addr_i,
    input  logic [DATA_WIDTH-1:0]     ctrl_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] ctrl_regdest_i,
    output logic                      rf_wb_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_wb_addr_o,
    output logic [DATA_WIDTH-1:0]     rf_wb_data_o,
    output logic                      misaligned_o,
    output logic                      bus_err_o,
    jedro_1_lsu_if.master             dram
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]             cnt;
    logic [1:0]                off_q, width_q;
    logic                      sign_q, store_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      accept, misal, timeout, ok, fail, done;
    logic [3:0]                we_st;
    logic [DATA_WIDTH-1:0]     wdata_st, ld;
    logic [7:0]                byte_v;
    logic [15:0]               half_v;

    assign ctrl_ready_o = state == IDLE;

    always_comb begin
        accept    = ctrl_valid_i & ctrl_ready_o;
        misal     = (ctrl_width_i == 2'b11) | (ctrl_width_i == 2'b01 & ctrl_addr_i[0])
                  | (ctrl_width_i == 2'b10 & ctrl_addr_i[1:0] != 2'b00);
        timeout   = cnt == CNT_LAST;
        ok        = state == WAIT & dram.ack & ~dram.err;
        fail      = state == WAIT & (dram.err | (timeout & ~dram.ack));
        done      = ok | fail;
        state_nxt = state == IDLE ? (accept & ~misal ? WAIT : IDLE) : (done ? IDLE : WAIT);
        we_st     = ctrl_width_i == 2'b00 ? 4'b0001 << ctrl_addr_i[1:0]
                  : ctrl_width_i == 2'b01 ? 4'b0011 << {ctrl_addr_i[1], 1'b0} : 4'b1111;
        wdata_st  = ctrl_width_i == 2'b00 ? {4{ctrl_wdata_i[7:0]}}
                  : ctrl_width_i == 2'b01 ? {2{ctrl_wdata_i[15:0]}} : ctrl_wdata_i;
        byte_v    = dram.rdata[{off_q, 3'b000} +: 8];
        half_v    = dram.rdata[{off_q[1], 4'b0000} +: 16];
        ld        = width_q == 2'b00 ? {{24{sign_q & byte_v[7]}}, byte_v}
                  : width_q == 2'b01 ? {{16{sign_q & half_v[15]}}, half_v} : dram.rdata;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt          <= '0;
            dram.stb     <= 1'b0;
            dram.we      <= 4'b0000;
            dram.addr    <= '0;
            dram.wdata   <= '0;
            off_q        <= 2'b00;
            width_q      <= 2'b00;
            sign_q       <= 1'b0;
            store_q      <= 1'b0;
            rd_q         <= '0;
            rf_wb_we_o   <= 1'b0;
            rf_wb_addr_o <= '0;
            rf_wb_data_o <= '0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            rf_wb_we_o   <= 1'b0;
            misaligned_o <= 1'b0;
            bus_err_o    <= 1'b0;
            cnt          <= state == WAIT && !done ? cnt + 1'b1 : '0;
            if (accept && misal) misaligned_o <= 1'b1;
            if (accept && !misal) begin
                dram.stb   <= 1'b1;
                dram.addr  <= {ctrl_addr_i[ADDR_WIDTH-1:2], 2'b00};
                dram.we    <= ctrl_we_i ? we_st : 4'b0000;
                dram.wdata <= wdata_st;
                off_q      <= ctrl_addr_i[1:0];
                width_q    <= ctrl_width_i;
                sign_q     <= ctrl_sign_ext_i;
                store_q    <= ctrl_we_i;
                rd_q       <= ctrl_regdest_i;
            end
            if (done) begin
                dram.stb  <= 1'b0;
                bus_err_o <= fail;
            end
            // loads to x0 are discarded like any other RISC-V write to x0
            if (ok && !store_q && rd_q != '0) begin
                rf_wb_we_o   <= 1'b1;
                rf_wb_addr_o <= rd_q;
                rf_wb_data_o <= ld;
            end
        end
    end
endmodule

// File: tb/tb_jedro_1_lsu.sv
// tb_jedro_1_lsu: directed and random transactions against a byte-addressed memory model;
// the RAM side is applied from the DUT's own strobes so store steering is checked end to end.
module tb_jedro_1_lsu;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0, we = 1'b0, sx = 1'b0;
    logic [1:0]  width = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic [4:0]  rd = '0;
    logic        ready, wb_we, misal, bus_err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  mem_m [256];
    logic [31:0] bmem  [64];

    jedro_1_lsu_if dram ();

    jedro_1_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .ctrl_valid_i(valid), .ctrl_ready_o(ready), .ctrl_we_i(we), .ctrl_width_i(width),
        .ctrl_sign_ext_i(sx), .ctrl_addr_i(addr), .ctrl_wdata_i(wdata), .ctrl_regdest_i(rd),
        .rf_wb_we_o(wb_we), .rf_wb_addr_o(wb_addr), .rf_wb_data_o(wb_data),
        .misaligned_o(misal), .bus_err_o(bus_err), .dram(dram.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int w, input logic [31:0] v);
        bmem[w] = v;
        for (int i = 0; i < 4; i++) mem_m[4*w+i] = v[8*i +: 8];
    endtask

    function automatic logic [31:0] model_word(input int w);
        return {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]};
    endfunction

    // mode: 0 ack, 1 err, 2 ack+err, 3 never respond
    task automatic run(input bit st, input logic [1:0] w, input bit s, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r, input int lat, input int mode);
        int n, off;
        bit bad;
        logic [31:0] exp_we, v;
        n   = w == 0 ? 1 : w == 1 ? 2 : w == 2 ? 4 : 0;
        off = int'(a[1:0]);
        bad = n == 0 || (off % n) != 0;
        @(negedge clk);
        valid = 1'b1; we = st; width = w; sx = s; addr = a; wdata = d; rd = r;
        chk("ready_idle", {31'b0, ready}, 32'd1);
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        if (bad) begin
            chk("misal_pulse", {31'b0, misal}, 32'd1);
            chk("misal_nostb", {31'b0, dram.stb}, 32'd0);
            chk("misal_ready", {31'b0, ready}, 32'd1);
            @(negedge clk);
            chk("misal_once", {31'b0, misal}, 32'd0);
            chk("misal_nostb2", {31'b0, dram.stb}, 32'd0);
            return;
        end
        exp_we = st ? ((32'd1 << n) - 1) << off : 32'd0;
        for (int c = 0; ; c++) begin
            chk("stb_held", {31'b0, dram.stb}, 32'd1);
            chk("addr", dram.addr, {a[31:2], 2'b00});
            chk("we", {28'b0, dram.we}, exp_we);
            chk("ready_busy", {31'b0, ready}, 32'd0);
            if (c == 0 && st)
                for (int i = 0; i < n; i++) chk("lane", {24'b0, dram.wdata[8*(off+i) +: 8]}, {24'b0, d[8*i +: 8]});
            if (mode == 3 && c == T - 1) break;
            if (mode != 3 && c == lat) begin
                dram.rdata = bmem[a[7:2]];
                dram.ack = mode != 1;
                dram.err = mode != 0;
                if (mode == 0 && st) begin
                    for (int j = 0; j < 4; j++) if (dram.we[j]) bmem[a[7:2]][8*j +: 8] = dram.wdata[8*j +: 8];
                    for (int i = 0; i < n; i++) mem_m[a[7:0] + 8'(i)] = d[8*i +: 8];
                end
                break;
            end
            @(negedge clk);
        end
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[a[7:0] + 8'(i)];
        if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        @(negedge clk);
        dram.ack = 1'b0;
        dram.err = 1'b0;
        chk("stb_drop", {31'b0, dram.stb}, 32'd0);
        chk("ready_back", {31'b0, ready}, 32'd1);
        chk("bus_err", {31'b0, bus_err}, {31'b0, mode != 0});
        chk("wb_we", {31'b0, wb_we}, {31'b0, mode == 0 && !st && r != 0});
        if (mode == 0 && !st && r != 0) begin
            chk("wb_addr", {27'b0, wb_addr}, {27'b0, r});
            chk("wb_data", wb_data, v);
        end
        if (mode == 0 && st) chk("ram_word", bmem[a[7:2]], model_word(int'(a[7:2])));
        @(negedge clk);
        chk("pulse_end_wb", {31'b0, wb_we}, 32'd0);
        chk("pulse_end_err", {31'b0, bus_err}, 32'd0);
    endtask

    initial begin
        dram.ack = 1'b0;
        dram.err = 1'b0;
        dram.rdata = '0;
        for (int w = 0; w < 64; w++) poke(w, $urandom);
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_stb", {31'b0, dram.stb}, 32'd0);
        chk("rst_we", {28'b0, dram.we}, 32'd0);
        chk("rst_wb", {31'b0, wb_we}, 32'd0);
        chk("rst_pulses", {30'b0, misal, bus_err}, 32'd0);
        rstn = 1'b1;

        poke(0, 32'd0);
        poke(1, 32'd0);
        run(1, 2'b01, 0, 32'h0, 32'h0000_FFFF, 5'd0, 0, 0);
        chk("sh0_wdata", dram.wdata, 32'hFFFF_FFFF);
        run(1, 2'b01, 0, 32'h4, 32'h0000_FFFF, 5'd0, 0, 0);
        chk("sh4_wdata", dram.wdata, 32'hFFFF_FFFF);
        chk("ram0", bmem[0], 32'h0000_FFFF);
        chk("ram4", bmem[1], 32'h0000_FFFF);
        run(1, 2'b01, 0, 32'h6, 32'h1234_ABCD, 5'd3, 1, 0);
        chk("sh6_wdata", dram.wdata, 32'hABCD_ABCD);
        chk("sh6_we", {28'b0, dram.we}, 32'hC);

        poke(0, 32'h80FF_0000);
        run(0, 2'b00, 1, 32'h3, 32'h0, 5'd5, 0, 0);
        chk("lb_sx", wb_data, 32'hFFFF_FF80);
        run(0, 2'b00, 0, 32'h3, 32'h0, 5'd5, 2, 0);
        chk("lbu_zx", wb_data, 32'h0000_0080);
        run(0, 2'b00, 1, 32'h3, 32'h0, 5'd0, 0, 0);
        run(0, 2'b01, 0, 32'h1, 32'h0, 5'd7, 0, 0);
        run(0, 2'b10, 0, 32'h2, 32'h0, 5'd7, 0, 0);
        run(0, 2'b11, 0, 32'h0, 32'h0, 5'd7, 0, 0);
        run(0, 2'b10, 0, 32'h8, 32'h0, 5'd9, 0, 3);
        run(0, 2'b10, 0, 32'h8, 32'h0, 5'd9, 1, 2);
        run(1, 2'b10, 0, 32'hC, 32'h5555_AAAA, 5'd0, 0, 1);

        @(negedge clk);
        dram.ack = 1'b1;
        dram.err = 1'b1;
        @(negedge clk);
        dram.ack = 1'b0;
        dram.err = 1'b0;
        chk("idle_ack_ignored", {29'b0, wb_we, bus_err, dram.stb}, 32'd0);
        chk("idle_ack_ready", {31'b0, ready}, 32'd1);

        @(negedge clk);
        valid = 1'b1; we = 1'b0; width = 2'b10; addr = 32'h10; rd = 5'd4;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        chk("prerst_stb", {31'b0, dram.stb}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_stb", {31'b0, dram.stb}, 32'd0);
        chk("async_rst_ready", {31'b0, ready}, 32'd1);
        chk("async_rst_wb", {30'b0, wb_we, bus_err}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run(1, 2'b10, 0, 32'h14, 32'hDEAD_BEEF, 5'd0, 0, 0);
        chk("post_rst_sw", bmem[5], 32'hDEAD_BEEF);

        for (int k = 0; k < 150; k++) begin
            automatic int m = $urandom_range(0, 9);
            automatic logic [1:0] w = $urandom_range(0, 15) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
            run(1'($urandom), w, 1'($urandom), 32'($urandom_range(0, 255)), $urandom,
                5'($urandom), $urandom_range(0, 4), m < 7 ? 0 : m == 7 ? 1 : m == 8 ? 2 : 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
